// File: rtl/axi_sram_slave.sv
// AXI slave backed by a 2^MEM_AW x 32-bit word SRAM, one transaction at a time.
// Define AXI_SRAM_SLAVE_STALL_EN to insert pseudo-random R/W beat stalls from an LFSR.
module axi_sram_slave #(
  parameter int MEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,

  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,

  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,

  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,

  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int ADDR_W = MEM_AW + 2;

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t             state;
  logic [3:0]         id_q;
  logic [7:0]         len_q;
  logic [7:0]         beat_q;
  logic [2:0]         size_q;
  logic [1:0]         burst_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  next_addr;
  logic               stall;
  logic               ar_hs;
  logic               aw_hs;
  logic               r_hs;
  logic               w_hs;
  logic               unused_ok;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

`ifdef AXI_SRAM_SLAVE_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; bit 0 withholds the next beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // A pending write takes priority over a read in the same idle cycle.
  assign awready = (state == IDLE) && !rst;
  assign arready = (state == IDLE) && !rst && !awvalid;
  assign wready  = (state == WR) && !rst && !stall;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign r_hs  = rvalid && rready;
  assign w_hs  = wvalid && wready;

  assign rresp = 2'b00;
  assign bresp = 2'b00;

  // WRAP and the reserved encoding advance like INCR; only FIXED holds.
  always_comb begin
    next_addr = addr_q;
    if (burst_q != 2'b00) begin
      next_addr = addr_q + (ADDR_W'(1) << size_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      rid     <= '0;
      rdata   <= '0;
      rlast   <= 1'b0;
      rvalid  <= 1'b0;
      bid     <= '0;
      bvalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q    <= awid;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= awburst;
            addr_q  <= awaddr[ADDR_W-1:0];
            beat_q  <= '0;
            state   <= WR;
          end else if (ar_hs) begin
            id_q    <= arid;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            addr_q  <= araddr[ADDR_W-1:0];
            beat_q  <= '0;
            rid     <= arid;
            state   <= RD;
            if (!stall) begin
              rvalid <= 1'b1;
              rdata  <= mem[araddr[ADDR_W-1:2]];
              rlast  <= (arlen == 8'd0);
            end
          end
        end

        RD: begin
          if (r_hs) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              state  <= IDLE;
            end else begin
              addr_q <= next_addr;
              beat_q <= beat_q + 8'd1;
              if (!stall) begin
                rdata <= mem[next_addr[ADDR_W-1:2]];
                rlast <= ((beat_q + 8'd1) == len_q);
              end else begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
              end
            end
          end else if (!rvalid && !stall) begin
            // A beat withheld by a stall is presented once the stall clears.
            rvalid <= 1'b1;
            rdata  <= mem[addr_q[ADDR_W-1:2]];
            rlast  <= (beat_q == len_q);
          end
        end

        WR: begin
          if (w_hs) begin
            if (beat_q == len_q) begin
              bvalid <= 1'b1;
              bid    <= id_q;
              state  <= WRESP;
            end else begin
              addr_q <= next_addr;
              beat_q <= beat_q + 8'd1;
            end
          end
        end

        WRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Memory is never reset; w_hs is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast,
                       araddr[31:ADDR_W], awaddr[31:ADDR_W]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: write/read bursts, strobes, priority,
// read backpressure, mid-burst reset, and (with AXI_SRAM_SLAVE_STALL_EN) stalls.
module tb_axi_sram_slave;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int vectors = 0;
  int miscompares = 0;
  int wait_cycles = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];

  axi_sram_slave #(.MEM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  task automatic applyStimulus(input logic reset_value);
    rst = reset_value;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    arlock = 1'b1; arcache = 4'hF; arprot = 3'h7; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    awlock = 1'b1; awcache = 4'hF; awprot = 3'h7; awvalid = 1'b0;
    wid = 4'hA; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b1;
    bready = 1'b0;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    #1;
    while (!awready && n < TIMEOUT) begin n++; @(negedge clk); #1; end
    if (!awready) timeoutFail("aw_handshake");
    else begin @(posedge clk); @(negedge clk); end
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    n = 0;
    #1;
    while (!arready && n < TIMEOUT) begin n++; @(negedge clk); #1; end
    if (!arready) timeoutFail("ar_handshake");
    else begin @(posedge clk); @(negedge clk); end
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    n = 0;
    #1;
    while (!wready && n < TIMEOUT) begin wait_cycles++; n++; @(negedge clk); #1; end
    if (!wready) timeoutFail("w_handshake");
    else begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic b_wait(input logic [3:0] id, input string tag);
    int n;
    bready = 1'b1;
    n = 0;
    #1;
    while (!bvalid && n < TIMEOUT) begin n++; @(negedge clk); #1; end
    if (!bvalid) timeoutFail({tag, "_b_handshake"});
    else begin
      checkOutput({tag, "_bid"}, {28'd0, bid}, {28'd0, id});
      checkOutput({tag, "_bresp"}, {30'd0, bresp}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    bready = 1'b0;
  endtask

  task automatic r_beat(input string tag, input logic [3:0] id, input logic [31:0] exp_data,
                        input logic exp_last);
    int n;
    n = 0;
    #1;
    while (!(rvalid && rready) && n < TIMEOUT) begin wait_cycles++; n++; @(negedge clk); #1; end
    if (!rvalid) timeoutFail({tag, "_r_handshake"});
    else begin
      checkOutput({tag, "_rdata"}, rdata, exp_data);
      checkOutput({tag, "_rlast"}, {31'd0, rlast}, {31'd0, exp_last});
      checkOutput({tag, "_rid"}, {28'd0, rid}, {28'd0, id});
      checkOutput({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
`ifndef AXI_SRAM_SLAVE_STALL_EN
      checkOutput({tag, "_latency"}, n, 32'd0);
`endif
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input string tag);
    aw_send(id, addr, len, burst);
    for (int b = 0; b <= int'(len); b++) w_beat(wbuf[b], sbuf[b], b == int'(len));
    wvalid = 1'b0;
    b_wait(id, tag);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input string tag);
    ar_send(id, addr, len, burst);
    for (int b = 0; b <= int'(len); b++) r_beat($sformatf("%s_b%0d", tag, b), id, rbuf[b], b == int'(len));
  endtask

  initial begin
    applyStimulus(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("rst_bvalid", {31'd0, bvalid}, 32'd0);
    checkOutput("rst_wready", {31'd0, wready}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_rid_bid", {24'd0, rid, bid}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("idle_awready", {31'd0, awready}, 32'd1);
    checkOutput("idle_arready", {31'd0, arready}, 32'd1);
    @(negedge clk);

    $display("[TB] single write/read");
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    write_burst(4'd3, 32'h100, 8'd0, 2'b01, "single_wr");
    rbuf[0] = 32'hDEADBEEF;
    read_burst(4'd5, 32'h100, 8'd0, 2'b01, "single_rd");
    read_burst(4'd6, 32'h4100, 8'd0, 2'b01, "alias_rd");

    $display("[TB] byte strobes");
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
    write_burst(4'd1, 32'h300, 8'd0, 2'b01, "strb_fill");
    wbuf[0] = 32'h11223344; sbuf[0] = 4'h5;
    write_burst(4'd2, 32'h300, 8'd0, 2'b01, "strb_wr");
    rbuf[0] = 32'hFF22FF44;
    read_burst(4'd2, 32'h300, 8'd0, 2'b01, "strb_rd");

    $display("[TB] fixed burst");
    wbuf[0] = 32'h11111111; sbuf[0] = 4'hF;
    wbuf[1] = 32'h22222222; sbuf[1] = 4'hF;
    wbuf[2] = 32'h33333333; sbuf[2] = 4'h1;
    write_burst(4'd4, 32'h600, 8'd2, 2'b00, "fixed_wr");
    rbuf[0] = 32'h22222233; rbuf[1] = 32'h22222233;
    read_burst(4'd4, 32'h600, 8'd1, 2'b00, "fixed_rd");

    $display("[TB] incr read with backpressure");
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0A0_0000 + i; sbuf[i] = 4'hF; end
    write_burst(4'd7, 32'h200, 8'd3, 2'b01, "incr_wr");
    ar_send(4'd8, 32'h200, 8'd3, 2'b01);
    r_beat("hold_b0", 4'd8, 32'hA0A00000, 1'b0);
    rready = 1'b0;
    begin
      int n;
      n = 0;
      #1;
      while (!rvalid && n < TIMEOUT) begin n++; @(negedge clk); #1; end
      if (!rvalid) timeoutFail("hold_b1_present");
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checkOutput($sformatf("hold_b1_valid%0d", k), {31'd0, rvalid}, 32'd1);
      checkOutput($sformatf("hold_b1_data%0d", k), rdata, 32'hA0A00001);
      checkOutput($sformatf("hold_b1_last%0d", k), {31'd0, rlast}, 32'd0);
    end
    rready = 1'b1;
    r_beat("hold_b1", 4'd8, 32'hA0A00001, 1'b0);
    r_beat("hold_b2", 4'd8, 32'hA0A00002, 1'b0);
    r_beat("hold_b3", 4'd8, 32'hA0A00003, 1'b1);

    $display("[TB] write/read priority");
    awid = 4'd2; awaddr = 32'h400; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd9; araddr = 32'h400; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    checkOutput("prio_awready", {31'd0, awready}, 32'd1);
    checkOutput("prio_arready", {31'd0, arready}, 32'd0);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    #1;
    checkOutput("prio_arready_wr", {31'd0, arready}, 32'd0);
    w_beat(32'h55AA1234, 4'hF, 1'b1);
    wvalid = 1'b0;
    #1;
    checkOutput("prio_bvalid", {31'd0, bvalid}, 32'd1);
    checkOutput("prio_arready_wresp", {31'd0, arready}, 32'd0);
    @(negedge clk);
    b_wait(4'd2, "prio");
    rbuf[0] = 32'h55AA1234;
    read_burst(4'd9, 32'h400, 8'd0, 2'b01, "prio_rd");

    $display("[TB] reset mid-burst");
    wbuf[0] = 32'h0BAD0BAD; sbuf[0] = 4'hF;
    write_burst(4'd1, 32'h508, 8'd0, 2'b01, "pre_rst");
    aw_send(4'd6, 32'h500, 8'd7, 2'b01);
    w_beat(32'hC0C0C0C0, 4'hF, 1'b0);
    w_beat(32'hC1C1C1C1, 4'hF, 1'b0);
    wdata = 32'hC2C2C2C2; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; wvalid = 1'b0; bready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("rst_abort_bvalid%0d", k), {31'd0, bvalid}, 32'd0);
      checkOutput($sformatf("rst_abort_wready%0d", k), {31'd0, wready}, 32'd0);
      @(negedge clk);
    end
    bready = 1'b0;
    rbuf[0] = 32'hC0C0C0C0; rbuf[1] = 32'hC1C1C1C1; rbuf[2] = 32'h0BAD0BAD;
    read_burst(4'd3, 32'h500, 8'd2, 2'b01, "rst_rd");

    $display("[TB] 16-beat burst and address wrap");
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = 32'h1000_0000 + i * 32'h0001_0203; sbuf[i] = 4'hF; rbuf[i] = wbuf[i];
    end
    write_burst(4'd5, 32'h0, 8'd15, 2'b01, "long_wr");
    read_burst(4'd5, 32'h0, 8'd15, 2'b01, "long_rd");
    wbuf[0] = 32'h7E57CAFE; sbuf[0] = 4'hF;
    write_burst(4'd11, 32'h3FFC, 8'd0, 2'b01, "wrap_wr");
    rbuf[0] = 32'h7E57CAFE; rbuf[1] = 32'h1000_0000;
    read_burst(4'd12, 32'h3FFC, 8'd1, 2'b01, "wrap_rd");

`ifdef AXI_SRAM_SLAVE_STALL_EN
    checkOutput("stall_seen", {31'd0, wait_cycles > 0}, 32'd1);
`else
    checkOutput("no_stall", wait_cycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
